// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall sequencer: control-word field positions
// and the multiplier-sequencing FSM state encoding.
package hazard_stall_ctrl_pkg;

   localparam int CW_MUL    = 22;
   localparam int CW_RS_HI  = 21;
   localparam int CW_RS_LO  = 17;
   localparam int CW_RT_HI  = 16;
   localparam int CW_RT_LO  = 12;
   localparam int CW_RD_HI  = 11;
   localparam int CW_RD_LO  = 7;
   localparam int CW_WRF    = 6;
   localparam int CW_MUXREG = 3;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MUL_START = 2'd1,
      MUL_WAIT  = 2'd2,
      MUL_DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the core datapath (master) and the stall sequencer (slave).
// With HAZ_PERF_CNT_EN defined the bundle also carries the two stall performance counters.
interface hazard_stall_ctrl_if #(
   parameter int CW = 32
);

   logic [CW-1:0] ctrl_id;
   logic [CW-1:0] ctrl_ex;
   logic [CW-1:0] ctrl_mem;
   logic [CW-1:0] ctrl_wb;
   logic          mul_done;
   logic          mul_idle;
   logic          pc_stall;
   logic          id_stall;
   logic          ex_bubble;
   logic          ex_hold;
   logic          mul_start;
   logic          mul_err;
`ifdef HAZ_PERF_CNT_EN
   logic [15:0]   raw_stall_cnt;
   logic [15:0]   mul_stall_cnt;
`endif

   modport master (
      output ctrl_id, ctrl_ex, ctrl_mem, ctrl_wb, mul_done, mul_idle,
      input  pc_stall, id_stall, ex_bubble, ex_hold, mul_start, mul_err
`ifdef HAZ_PERF_CNT_EN
      , input raw_stall_cnt, mul_stall_cnt
`endif
   );

   modport slave (
      input  ctrl_id, ctrl_ex, ctrl_mem, ctrl_wb, mul_done, mul_idle,
      output pc_stall, id_stall, ex_bubble, ex_hold, mul_start, mul_err
`ifdef HAZ_PERF_CNT_EN
      , output raw_stall_cnt, mul_stall_cnt
`endif
   );

endinterface

// File: rtl/hazard_stall_ctrl_raw_compare.sv
// Read-after-write match of one producer stage against the decode-stage source registers.
module hazard_stall_ctrl_raw_compare #(
   parameter int RA = 5
) (
   input  logic          prod_wr,
   input  logic [RA-1:0] prod_rd,
   input  logic [RA-1:0] id_rs,
   input  logic [RA-1:0] id_rt,
   input  logic          id_rt_used,
   output logic          hit
);

   logic rd_live;

   // r0 is hard-wired zero, so a write to it never produces anything to wait for
   assign rd_live = prod_wr && (prod_rd != '0);
   assign hit     = rd_live && ((prod_rd == id_rs) || (id_rt_used && (prod_rd == id_rt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble sequencer for the 5-stage core: RAW detection against EX/MEM/WB and
// start/done sequencing of the multi-cycle multiplier. Optional counters: HAZ_PERF_CNT_EN.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int CW          = 32,
   parameter int RA          = 5,
   parameter int MUL_TIMEOUT = 48,
   parameter int TW          = 6
) (
   input  logic              CLK,
   input  logic              Rst,
   hazard_stall_ctrl_if.slave bus
);

   logic [CW-1:0] ctrl_id;
   logic [CW-1:0] ctrl_ex;
   logic [CW-1:0] ctrl_mem;
   logic [CW-1:0] ctrl_wb;
   logic [RA-1:0] id_rs;
   logic [RA-1:0] id_rt;
   logic          id_rt_used;
   logic [2:0]    hit;
   logic          raw_any;
   logic          mul_req;
   logic          unused_ctrl_bits;

   assign ctrl_id  = bus.ctrl_id;
   assign ctrl_ex  = bus.ctrl_ex;
   assign ctrl_mem = bus.ctrl_mem;
   assign ctrl_wb  = bus.ctrl_wb;

   assign id_rs      = ctrl_id[CW_RS_HI:CW_RS_LO];
   assign id_rt      = ctrl_id[CW_RT_HI:CW_RT_LO];
   assign id_rt_used = ~ctrl_id[CW_MUXREG];
   assign mul_req    = ctrl_ex[CW_MUL];
   assign unused_ctrl_bits = ^{ctrl_id, ctrl_ex, ctrl_mem, ctrl_wb};

   // WB is checked too: the register file has no write-through on the shared edge
   hazard_stall_ctrl_raw_compare #(.RA(RA)) u_cmp_ex (
      .prod_wr   (ctrl_ex[CW_WRF]),
      .prod_rd   (ctrl_ex[CW_RD_HI:CW_RD_LO]),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_rt_used(id_rt_used),
      .hit       (hit[0])
   );

   hazard_stall_ctrl_raw_compare #(.RA(RA)) u_cmp_mem (
      .prod_wr   (ctrl_mem[CW_WRF]),
      .prod_rd   (ctrl_mem[CW_RD_HI:CW_RD_LO]),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_rt_used(id_rt_used),
      .hit       (hit[1])
   );

   hazard_stall_ctrl_raw_compare #(.RA(RA)) u_cmp_wb (
      .prod_wr   (ctrl_wb[CW_WRF]),
      .prod_rd   (ctrl_wb[CW_RD_HI:CW_RD_LO]),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .id_rt_used(id_rt_used),
      .hit       (hit[2])
   );

   assign raw_any = |hit;

   state_e        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          skip_q, skip_d;
   logic          pc_stall_c, id_stall_c, ex_bubble_c, ex_hold_c, mul_start_c;

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         skip_q  <= skip_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      skip_d      = 1'b0;
      pc_stall_c  = 1'b0;
      id_stall_c  = 1'b0;
      ex_bubble_c = 1'b0;
      ex_hold_c   = 1'b0;
      mul_start_c = 1'b0;
      case (state_q)
         RUN: begin
            if (raw_any) begin
               pc_stall_c  = 1'b1;
               id_stall_c  = 1'b1;
               ex_bubble_c = 1'b1;
            end else if (mul_req && !skip_q) begin
               // skip_q masks the multiply that just drained from restarting
               if (bus.mul_idle) begin
                  state_d = MUL_START;
               end else begin
                  ex_hold_c  = 1'b1;
                  pc_stall_c = 1'b1;
                  id_stall_c = 1'b1;
               end
            end
         end
         MUL_START: begin
            mul_start_c = 1'b1;
            ex_hold_c   = 1'b1;
            pc_stall_c  = 1'b1;
            id_stall_c  = 1'b1;
            cnt_d       = '0;
            state_d     = MUL_WAIT;
         end
         MUL_WAIT: begin
            ex_hold_c  = 1'b1;
            pc_stall_c = 1'b1;
            id_stall_c = 1'b1;
            cnt_d      = cnt_q + TW'(1);
            if (bus.mul_done) begin
               state_d = MUL_DRAIN;
            end else if (cnt_q == TW'(MUL_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = MUL_DRAIN;
            end
         end
         MUL_DRAIN: begin
            // ex_hold low lets D1 capture the product
            pc_stall_c = 1'b1;
            id_stall_c = 1'b1;
            skip_d     = 1'b1;
            state_d    = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign bus.pc_stall  = pc_stall_c  & ~Rst;
   assign bus.id_stall  = id_stall_c  & ~Rst;
   assign bus.ex_bubble = ex_bubble_c & ~Rst;
   assign bus.ex_hold   = ex_hold_c   & ~Rst;
   assign bus.mul_start = mul_start_c & ~Rst;
   assign bus.mul_err   = err_q;

`ifdef HAZ_PERF_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      if (en && (v != 16'hFFFF)) return v + 16'd1;
      return v;
   endfunction

   logic [15:0] raw_cnt_q, raw_cnt_d;
   logic [15:0] mul_cnt_q, mul_cnt_d;

   always_comb begin
      raw_cnt_d = sat_inc(raw_cnt_q, ex_bubble_c);
      mul_cnt_d = sat_inc(mul_cnt_q, ex_hold_c);
   end

   always_ff @(posedge CLK or posedge Rst) begin
      if (Rst) begin
         raw_cnt_q <= '0;
         mul_cnt_q <= '0;
      end else begin
         raw_cnt_q <= raw_cnt_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   assign bus.raw_stall_cnt = raw_cnt_q;
   assign bus.mul_stall_cnt = mul_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: RAW stalls, r0/unused-rt immunity, multiplier
// sequencing, timeout, done/timeout race and asynchronous reset mid-multiply.
module tb_hazard_stall_ctrl;

   logic CLK;
   logic Rst;
   int   n_cmp;
   int   n_err;

   hazard_stall_ctrl_if #(.CW(32)) bif ();

   hazard_stall_ctrl #(
      .CW(32), .RA(5), .MUL_TIMEOUT(48), .TW(6)
   ) dut (
      .CLK(CLK),
      .Rst(Rst),
      .bus(bif)
   );

   // {pc_stall, id_stall, ex_bubble, ex_hold, mul_start, mul_err}
   wire [5:0] outs = {bif.pc_stall, bif.id_stall, bif.ex_bubble,
                      bif.ex_hold, bif.mul_start, bif.mul_err};

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] cw(input logic mul, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic wr, input logic muxreg);
      logic [31:0] w;
      w        = '0;
      w[22]    = mul;
      w[21:17] = rs;
      w[16:12] = rt;
      w[11:7]  = rd;
      w[6]     = wr;
      w[3]     = muxreg;
      return w;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bif.ctrl_id  = '0;
      bif.ctrl_ex  = '0;
      bif.ctrl_mem = '0;
      bif.ctrl_wb  = '0;
      bif.mul_done = 1'b0;
      bif.mul_idle = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      Rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", outs, 6'b000000); end
`ifdef HAZ_PERF_CNT_EN
      n_cmp++;
      if (bif.raw_stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_raw_cnt got=%0d exp=0", bif.raw_stall_cnt); end
      n_cmp++;
      if (bif.mul_stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_mul_cnt got=%0d exp=0", bif.mul_stall_cnt); end
`endif
      Rst = 1'b0;
      tick();
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL post_reset_idle got=%b exp=%b", outs, 6'b000000); end
   endtask

   task automatic test_raw_ex();
      logic [31:0] prod;
      prod = cw(1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
      tick();
      bif.ctrl_id = cw(1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
      bif.ctrl_ex = prod;
      #1;
      n_cmp++;
      if (outs !== 6'b111000) begin n_err++; $display("FAIL raw_at_ex got=%b exp=%b", outs, 6'b111000); end
      tick();
      bif.ctrl_ex  = '0;
      bif.ctrl_mem = prod;
      #1;
      n_cmp++;
      if (outs !== 6'b111000) begin n_err++; $display("FAIL raw_at_mem got=%b exp=%b", outs, 6'b111000); end
      tick();
      bif.ctrl_mem = '0;
      bif.ctrl_wb  = prod;
      #1;
      n_cmp++;
      if (outs !== 6'b111000) begin n_err++; $display("FAIL raw_at_wb got=%b exp=%b", outs, 6'b111000); end
      tick();
      bif.ctrl_wb = '0;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL raw_released got=%b exp=%b", outs, 6'b000000); end
      // rt operand hazard from MEM
      tick();
      bif.ctrl_id  = cw(1'b0, 5'd1, 5'd4, 5'd0, 1'b0, 1'b0);
      bif.ctrl_mem = cw(1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (outs !== 6'b111000) begin n_err++; $display("FAIL raw_rt_mem got=%b exp=%b", outs, 6'b111000); end
      clear_inputs();
   endtask

   task automatic test_immunity();
      tick();
      bif.ctrl_id = cw(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bif.ctrl_ex = cw(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL r0_immune got=%b exp=%b", outs, 6'b000000); end
      tick();
      bif.ctrl_id = cw(1'b0, 5'd2, 5'd7, 5'd0, 1'b0, 1'b1);
      bif.ctrl_ex = cw(1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL unused_rt_immune got=%b exp=%b", outs, 6'b000000); end
      tick();
      bif.ctrl_id = cw(1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
      bif.ctrl_wb = cw(1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL no_write_immune got=%b exp=%b", outs, 6'b000000); end
      clear_inputs();
   endtask

   task automatic test_mul_busy();
      tick();
      bif.ctrl_ex  = cw(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bif.mul_idle = 1'b0;
      #1;
      n_cmp++;
      if (outs !== 6'b110100) begin n_err++; $display("FAIL mul_busy_c0 got=%b exp=%b", outs, 6'b110100); end
      tick();
      n_cmp++;
      if (outs !== 6'b110100) begin n_err++; $display("FAIL mul_busy_c1 got=%b exp=%b", outs, 6'b110100); end
      bif.ctrl_ex  = '0;
      bif.mul_idle = 1'b1;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL mul_busy_cleared got=%b exp=%b", outs, 6'b000000); end
   endtask

   task automatic test_mul_nominal();
      int holds;
      int starts;
      holds  = 0;
      starts = 0;
      tick();
      bif.ctrl_ex  = cw(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bif.mul_idle = 1'b1;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL mul_req_run got=%b exp=%b", outs, 6'b000000); end
      tick();
      n_cmp++;
      if (outs !== 6'b110110) begin n_err++; $display("FAIL mul_start got=%b exp=%b", outs, 6'b110110); end
      holds  += int'(bif.ex_hold);
      starts += int'(bif.mul_start);
      for (int w = 1; w <= 17; w++) begin
         tick();
         if (w == 17) bif.mul_done = 1'b1;
         #1;
         n_cmp++;
         if (outs !== 6'b110100) begin n_err++; $display("FAIL mul_wait_%0d got=%b exp=%b", w, outs, 6'b110100); end
         holds  += int'(bif.ex_hold);
         starts += int'(bif.mul_start);
      end
      tick();
      bif.mul_done = 1'b0;
      #1;
      n_cmp++;
      if (outs !== 6'b110000) begin n_err++; $display("FAIL mul_drain got=%b exp=%b", outs, 6'b110000); end
      tick();
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL mul_no_restart got=%b exp=%b", outs, 6'b000000); end
      starts += int'(bif.mul_start);
      tick();
      bif.ctrl_ex = '0;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL mul_back_run got=%b exp=%b", outs, 6'b000000); end
      n_cmp++;
      if (holds !== 18) begin n_err++; $display("FAIL mul_hold_cycles got=%0d exp=18", holds); end
      n_cmp++;
      if (starts !== 1) begin n_err++; $display("FAIL mul_start_pulses got=%0d exp=1", starts); end
   endtask

   task automatic test_timeout();
      int bad;
      bad = 0;
      tick();
      bif.ctrl_ex = cw(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      tick();
      n_cmp++;
      if (outs !== 6'b110110) begin n_err++; $display("FAIL to_start got=%b exp=%b", outs, 6'b110110); end
      for (int w = 1; w <= 48; w++) begin
         tick();
         if (outs !== 6'b110100) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL to_wait_cycles got=%0d bad exp=0 bad", bad); end
      tick();
      n_cmp++;
      if (outs !== 6'b110001) begin n_err++; $display("FAIL to_drain_err got=%b exp=%b", outs, 6'b110001); end
      tick();
      bif.ctrl_ex = '0;
      #1;
      n_cmp++;
      if (outs !== 6'b000001) begin n_err++; $display("FAIL to_run_sticky got=%b exp=%b", outs, 6'b000001); end
      tick();
      tick();
      n_cmp++;
      if (bif.mul_err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky got=%b exp=1", bif.mul_err); end
   endtask

   task automatic test_reset_mid();
      tick();
      bif.ctrl_ex = cw(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      n_cmp++;
      if (outs !== 6'b110101) begin n_err++; $display("FAIL rm_in_wait got=%b exp=%b", outs, 6'b110101); end
      #1;
      Rst = 1'b1;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL rm_async_zero got=%b exp=%b", outs, 6'b000000); end
      tick();
      bif.ctrl_ex = '0;
      tick();
      Rst = 1'b0;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL rm_released got=%b exp=%b", outs, 6'b000000); end
`ifdef HAZ_PERF_CNT_EN
      n_cmp++;
      if ({bif.raw_stall_cnt, bif.mul_stall_cnt} !== 32'd0) begin
         n_err++; $display("FAIL rm_counters got=%h exp=0", {bif.raw_stall_cnt, bif.mul_stall_cnt});
      end
`endif
      tick();
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL rm_no_start got=%b exp=%b", outs, 6'b000000); end
      // a bubble is only possible from RUN
      bif.ctrl_id = cw(1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);
      bif.ctrl_wb = cw(1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
      #1;
      n_cmp++;
      if (outs !== 6'b111000) begin n_err++; $display("FAIL rm_in_run got=%b exp=%b", outs, 6'b111000); end
      clear_inputs();
   endtask

   task automatic test_simultaneous();
      int bad;
      bad = 0;
      tick();
      bif.ctrl_ex = cw(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (outs !== 6'b110110) begin n_err++; $display("FAIL sim_start got=%b exp=%b", outs, 6'b110110); end
      for (int w = 1; w <= 48; w++) begin
         tick();
         if (w == 10) begin
            bif.ctrl_id  = cw(1'b0, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
            bif.ctrl_mem = cw(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
            #1;
            n_cmp++;
            if (outs !== 6'b110100) begin n_err++; $display("FAIL sim_raw_no_bubble got=%b exp=%b", outs, 6'b110100); end
         end
         if (w == 11) begin
            bif.ctrl_id  = '0;
            bif.ctrl_mem = '0;
         end
         if (w == 48) bif.mul_done = 1'b1;
         #1;
         if (outs !== 6'b110100) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL sim_wait_cycles got=%0d bad exp=0 bad", bad); end
      tick();
      bif.mul_done = 1'b0;
      #1;
      n_cmp++;
      if (outs !== 6'b110000) begin n_err++; $display("FAIL sim_done_wins got=%b exp=%b", outs, 6'b110000); end
      tick();
      bif.ctrl_ex = '0;
      #1;
      n_cmp++;
      if (outs !== 6'b000000) begin n_err++; $display("FAIL sim_back_run got=%b exp=%b", outs, 6'b000000); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      Rst   = 1'b1;
      clear_inputs();
      test_reset();
      test_raw_ex();
      test_immunity();
      test_mul_busy();
      test_mul_nominal();
      test_timeout();
      test_reset_mid();
      test_simultaneous();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencer for the 5-stage core. It detects read-after-write hazards between the decode-stage control word and the EX, MEM and WB control words.
- It sequences the multi-cycle multiplier through a start/done handshake, and freezes or bubbles the pipeline while either condition holds.
- Outputs drive PC hold, IF/ID hold, and a bubble that zeroes the word loaded into the ID/EX control register.

Parameters:
- CW, 32, control-word width; field layout below.
- RA, 5, register-address width.
- MUL_TIMEOUT, 48, maximum cycles spent in MUL_WAIT before abort.
- TW, 6, timeout counter width; must satisfy 2**TW > MUL_TIMEOUT.

Ports:
- CLK  in  1  system clock; all state is on the rising edge.
- Rst  in  1  asynchronous reset, active-high.
- ctrl_id  in  CW  decode-stage control word.
- ctrl_ex  in  CW  ID/EX control register output.
- ctrl_mem  in  CW  EX/MEM control register output.
- ctrl_wb  in  CW  MEM/WB control register output.
- mul_done  in  1  multiplier product valid; already synchronized into the CLK domain.
- mul_idle  in  1  multiplier ready for a new start.
- pc_stall  out  1  hold the PC.
- id_stall  out  1  hold the instruction/immediate/decode registers.
- ex_bubble  out  1  load zero into the ID/EX control register this cycle.
- ex_hold  out  1  hold the ID/EX, EX/MEM and D1/B1 registers (multiplier freeze).
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_err  out  1  sticky; set on multiplier timeout.

Behaviour:
- Control-word fields:
  - mul_ctrl [22]
  - rs [21:17]
  - rt [16:12]
  - rd [11:7]
  - wr_reg_file [6]
  - mux_reg [3]; 1 means rt is not read as an operand.
- Reset: all outputs 0, FSM in RUN, timeout counter 0.
- RAW hazard (combinational):
  - For each stage S in {ex, mem, wb}: S.wr_reg_file=1, S.rd != 0, and (S.rd == id.rs, or S.rd == id.rt with id.mux_reg=0).
  - Register 0 never causes a hazard.
  - WB is included because register-file write and read share an edge and there is no write-through.
- FSM states: RUN, MUL_START, MUL_WAIT, MUL_DRAIN.
- RUN:
  - If a RAW hazard exists: pc_stall=id_stall=ex_bubble=1; stay in RUN.
  - Else if ctrl_ex[22]=1 and mul_idle=1: go to MUL_START.
  - Else if ctrl_ex[22]=1 and mul_idle=0: ex_hold=pc_stall=id_stall=1; remain in RUN until mul_idle=1.
- MUL_START: mul_start=1 for exactly one cycle; ex_hold=pc_stall=id_stall=1; go to MUL_WAIT; clear the counter.
- MUL_WAIT:
  - Holds stay asserted and the counter increments.
  - mul_done=1: go to MUL_DRAIN.
  - Counter reaches MUL_TIMEOUT: set mul_err, go to MUL_DRAIN.
  - If mul_done arrives in the same cycle as the timeout, done wins and mul_err is not set.
- MUL_DRAIN: one cycle with ex_hold=0 so D1 captures the product, and pc_stall=id_stall=1. Then return to RUN.
- ctrl_ex[22] is ignored in the cycle after MUL_DRAIN, so the same multiply is not restarted.
- Priority: the multiplier sequence outranks RAW. A RAW hazard present while ex_hold is active produces no bubble, because ID/EX is frozen. RAW is re-evaluated in RUN.
- ex_bubble and ex_hold are never both 1.
- Latency: hazard-to-stall is combinational (same cycle). A RAW stall lasts until the producer leaves WB, at most 3 cycles.
- Multiply cost: 1 start cycle + N wait cycles + 1 drain cycle.
- Reset mid-multiply: FSM returns to RUN; mul_err clears; no start pulse follows.
- mul_err clears only on Rst.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined:
  - Adds outputs raw_stall_cnt[15:0] and mul_stall_cnt[15:0].
  - raw_stall_cnt increments on each RUN-state RAW stall cycle; mul_stall_cnt increments on each cycle in which ex_hold=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Field index constants: CW_MUL=22, CW_RS_HI/LO, CW_RT_HI/LO, CW_RD_HI/LO, CW_WRF=6, CW_MUXREG=3.
  - FSM state encoding: RUN=2'd0, MUL_START=2'd1, MUL_WAIT=2'd2, MUL_DRAIN=2'd3.
- One sub-module, raw_compare: one producer stage against the decode rs/rt. It is instantiated three times.

Test Plan:
- RAW at EX: ctrl_ex rd=5, wr=1; ctrl_id rs=5 -> pc_stall=id_stall=ex_bubble=1 that cycle. After the producer advances through MEM and WB, 3 stall cycles in total, then 0.
- r0 and unused-rt immunity:
  - ctrl_ex rd=0, wr=1; id rs=0 -> no stall.
  - id rt=7, mux_reg=1; ex rd=7 -> no stall.
- Multiply nominal: ctrl_ex[22]=1, mul_idle=1 -> mul_start pulses 1 cycle. mul_done arrives 17 cycles later. ex_hold is high for 1+17 cycles, then MUL_DRAIN for 1 cycle, then RUN. No second start pulse.
- Timeout: never assert mul_done -> mul_err=1 after 48 MUL_WAIT cycles, then 1 MUL_DRAIN cycle, then RUN. mul_err stays 1 until Rst.
- Simultaneous: mul_done in the timeout cycle -> mul_err=0. A RAW hazard during MUL_WAIT -> ex_bubble=0.
- Reset mid-operation: assert Rst in MUL_WAIT -> all outputs 0 immediately (async). After release, FSM is in RUN. With HAZ_PERF_CNT_EN defined, the counters read 0.
